coh_directory_n: RTL and testbench

//  N-cache directory controller with a round-robin arbiter, a full-map sharer vector and a dirty-owner record per line.

---
 rtl/coh_directory_n.sv | 153 +++++++++++++++
 tb/tb_coh_directory_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coh_directory_n.sv
// Full-map coherence directory: round-robin arbitration over NCACHE ports, one transaction at a
// time, dirty-owner recall by write-back and targeted invalidation on exclusive grants.
module coh_directory_n #(
    parameter int unsigned NCACHE = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned ID_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*NCACHE-1:0]        req,
    input  logic [ADDR_W*NCACHE-1:0]   req_addr,
    input  logic [DATA_W*NCACHE-1:0]   back_data,
    output logic [NCACHE-1:0]          blk_ok,
    output logic [DATA_W-1:0]          blk_data,
    output logic [NCACHE-1:0]          inval,
    output logic [ADDR_W-1:0]          blocknum,
    output logic [NCACHE-1:0]          wb_req
);

    localparam int unsigned Lines = 2 ** ADDR_W;

    typedef enum logic [1:0] {StArb, StWait, StServe} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     g_id_q, g_id_d;
    logic [ADDR_W-1:0]   g_addr_q, g_addr_d;
    logic                g_excl_q, g_excl_d;

    logic [NCACHE-1:0]   sharers_q [Lines];
    logic [Lines-1:0]    owner_v_q;
    logic [ID_W-1:0]     owner_q [Lines];
    logic [DATA_W-1:0]   mem_q [Lines];

    logic                found;
    logic [ID_W-1:0]     pick_id;
    logic [1:0]          pick_code;
    logic [ADDR_W-1:0]   pick_addr;
    logic [ID_W-1:0]     cur_owner;
    logic                wb_done;
    logic [ID_W-1:0]     next_ptr;
    logic [NCACHE-1:0]   g_onehot;

    // Round-robin scan starting at rr_ptr; only read (01) and excl (10) codes compete.
    always_comb begin
        int idx;
        found     = 1'b0;
        pick_id   = '0;
        pick_code = 2'b00;
        idx       = 0;
        for (int k = 0; k < int'(NCACHE); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NCACHE)) begin
                idx = idx - int'(NCACHE);
            end
            if (!found && (req[2*idx +: 2] == 2'b01 || req[2*idx +: 2] == 2'b10)) begin
                found     = 1'b1;
                pick_id   = ID_W'(idx);
                pick_code = req[2*idx +: 2];
            end
        end
        pick_addr = req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
    end

    assign cur_owner = owner_q[g_addr_q];
    assign wb_done   = (state_q == StWait) && (req[2*int'(cur_owner) +: 2] == 2'b11);
    assign next_ptr  = (int'(g_id_q) == int'(NCACHE) - 1) ? '0 : g_id_q + 1'b1;
    assign g_onehot  = NCACHE'(1) << g_id_q;

    always_comb begin
        state_d  = state_q;
        g_id_d   = g_id_q;
        g_addr_d = g_addr_q;
        g_excl_d = g_excl_q;
        blk_ok   = '0;
        blk_data = '0;
        inval    = '0;
        blocknum = '0;
        wb_req   = '0;
        unique case (state_q)
            StArb: begin
                if (found) begin
                    g_id_d   = pick_id;
                    g_addr_d = pick_addr;
                    g_excl_d = (pick_code == 2'b10);
                    // A foreign dirty owner must write back before anyone else sees the line.
                    if (owner_v_q[pick_addr] && (owner_q[pick_addr] != pick_id)) begin
                        state_d = StWait;
                    end else begin
                        state_d = StServe;
                    end
                end
            end
            StWait: begin
                wb_req[cur_owner] = 1'b1;
                if (wb_done) begin
                    state_d = StServe;
                end
            end
            StServe: begin
                blk_ok[g_id_q] = 1'b1;
                blk_data       = mem_q[g_addr_q];
                if (g_excl_q) begin
                    inval    = sharers_q[g_addr_q] & ~g_onehot;
                    blocknum = g_addr_q;
                end
                state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StArb;
            rr_ptr_q  <= '0;
            g_id_q    <= '0;
            g_addr_q  <= '0;
            g_excl_q  <= 1'b0;
            owner_v_q <= '0;
            for (int i = 0; i < int'(Lines); i++) begin
                sharers_q[i] <= '0;
                owner_q[i]   <= '0;
                mem_q[i]     <= '0;
            end
        end else begin
            state_q  <= state_d;
            g_id_q   <= g_id_d;
            g_addr_q <= g_addr_d;
            g_excl_q <= g_excl_d;
            if (wb_done) begin
                mem_q[g_addr_q]     <= back_data[int'(cur_owner)*DATA_W +: DATA_W];
                owner_v_q[g_addr_q] <= 1'b0;
                // A recalled owner keeps a clean read copy when the new request is a read.
                if (!g_excl_q) begin
                    sharers_q[g_addr_q][cur_owner] <= 1'b1;
                end
            end
            if (state_q == StServe) begin
                if (g_excl_q) begin
                    sharers_q[g_addr_q] <= '0;
                    owner_v_q[g_addr_q] <= 1'b1;
                    owner_q[g_addr_q]   <= g_id_q;
                end else begin
                    sharers_q[g_addr_q][g_id_q] <= 1'b1;
                end
                rr_ptr_q <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_coh_directory_n.sv
// Bench for coh_directory_n: cache agents, a transaction-level directory model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic with resets.
module tb_coh_directory_n;

    localparam int NC = 4;
    localparam int AW = 4;
    localparam int DW = 1;

    logic            clk;
    logic            reset;
    logic [2*NC-1:0] req;
    logic [AW*NC-1:0] req_addr;
    logic [DW*NC-1:0] back_data;
    logic [NC-1:0]   blk_ok;
    logic [DW-1:0]   blk_data;
    logic [NC-1:0]   inval;
    logic [AW-1:0]   blocknum;
    logic [NC-1:0]   wb_req;

    coh_directory_n #(.NCACHE(NC), .ADDR_W(AW), .DATA_W(DW), .ID_W(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .back_data(back_data),
        .blk_ok(blk_ok), .blk_data(blk_data), .inval(inval), .blocknum(blocknum),
        .wb_req(wb_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ncmp = 0;
    int nfail = 0;

    // Cache agents
    logic [NC-1:0] pend_v;
    bit   pend_excl [NC];
    int   pend_addr [NC];
    int   wb_delay [NC];
    int   wb_cnt [NC];
    bit   wb_data [NC];
    bit   rand_mode;
    bit   rst_next;

    // Directory model: current transaction plus per-line state
    int        m_phase;  // 0 arbitrating, 1 waiting for write-back, 2 granting
    int        m_id, m_addr, m_rr;
    bit        m_excl;
    logic [NC-1:0] m_sh [16];
    bit        m_ov [16];
    int        m_own [16];
    bit        m_mem [16];

    // Captures
    logic [NC-1:0] cap_wb;
    logic [NC-1:0] last_ok, last_inval;
    logic [AW-1:0] last_bn;
    logic          last_data;
    logic [21:0]   cap_all;
    int            wb_cycles;
    int            grants[$];
    int            cyc = 0;

    task automatic model_reset();
        m_phase = 0; m_id = 0; m_addr = 0; m_rr = 0; m_excl = 0;
        for (int a = 0; a < 16; a++) begin
            m_sh[a] = '0; m_ov[a] = 0; m_own[a] = 0; m_mem[a] = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int code_of(input int i);
        return int'(req[2*i +: 2]);
    endfunction

    task automatic cycle();
        logic [NC-1:0] e_ok, e_inval, e_wb;
        logic [AW-1:0] e_bn;
        logic          e_data;
        bit ans, spur;
        int c;
        @(negedge clk);
        cyc++;
        // Expected outputs from the model's view of the current transaction
        e_ok = '0; e_inval = '0; e_wb = '0; e_bn = '0; e_data = 1'b0;
        if (m_phase == 1) e_wb = NC'(1 << m_own[m_addr]);
        if (m_phase == 2) begin
            e_ok   = NC'(1 << m_id);
            e_data = m_mem[m_addr];
            if (m_excl) begin
                e_inval = m_sh[m_addr] & ~NC'(1 << m_id);
                e_bn    = AW'(m_addr);
            end
        end
        ncmp++;
        if (blk_ok !== e_ok || blk_data !== e_data || inval !== e_inval ||
            blocknum !== e_bn || wb_req !== e_wb) begin
            nfail++;
            $display("FAIL outputs cyc %0d: got ok=%b data=%b inval=%b bn=%0d wb=%b want ok=%b data=%b inval=%b bn=%0d wb=%b",
                     cyc, blk_ok, blk_data, inval, blocknum, wb_req,
                     e_ok, e_data, e_inval, e_bn, e_wb);
        end
        cap_wb  = wb_req;
        cap_all = {blk_ok, blk_data, inval, blocknum, wb_req, 1'b0};
        if (wb_req == 4'b0010) wb_cycles++;
        if (blk_ok != 0) begin
            last_ok = blk_ok; last_data = blk_data; last_inval = inval; last_bn = blocknum;
            for (int i = 0; i < NC; i++) if (blk_ok[i]) grants.push_back(i);
        end
        // Agents react and drive inputs for the coming edge
        reset = rst_next;
        for (int i = 0; i < NC; i++) begin
            if (blk_ok[i]) pend_v[i] = 1'b0;
            if (wb_req[i]) wb_cnt[i]++; else wb_cnt[i] = 0;
            ans = wb_req[i] && (wb_cnt[i] >= wb_delay[i]);
            if (rand_mode && !pend_v[i] && !ans && $urandom_range(0, 3) == 0) begin
                pend_v[i]    = 1'b1;
                pend_excl[i] = ($urandom_range(0, 2) == 0);
                pend_addr[i] = $urandom_range(0, 3);
                wb_delay[i]  = $urandom_range(1, 4);
                wb_data[i]   = 1'($urandom_range(0, 1));
            end
            spur = rand_mode && !pend_v[i] && !wb_req[i] && $urandom_range(0, 7) == 0;
            c = (ans || spur) ? 3 : (pend_v[i] ? (pend_excl[i] ? 2 : 1) : 0);
            req[2*i +: 2]       = 2'(c);
            req_addr[AW*i +: AW] = AW'(pend_addr[i]);
            back_data[i]         = spur ? 1'($urandom_range(0, 1)) : wb_data[i];
        end
        // Advance model with the inputs the DUT samples at the coming edge
        if (reset) begin
            model_reset();
        end else if (m_phase == 0) begin
            for (int k = 0; k < NC; k++) begin
                int i = (m_rr + k) % NC;
                int a = int'(req_addr[AW*i +: AW]);
                if (code_of(i) == 1 || code_of(i) == 2) begin
                    m_id = i; m_addr = a; m_excl = (code_of(i) == 2);
                    m_phase = (m_ov[a] && m_own[a] != i) ? 1 : 2;
                    break;
                end
            end
        end else if (m_phase == 1) begin
            int o = m_own[m_addr];
            if (code_of(o) == 3) begin
                m_mem[m_addr] = back_data[o];
                m_ov[m_addr]  = 0;
                if (!m_excl) m_sh[m_addr][o] = 1'b1;
                m_phase = 2;
            end
        end else begin
            if (m_excl) begin
                m_sh[m_addr] = '0; m_ov[m_addr] = 1; m_own[m_addr] = m_id;
            end else begin
                m_sh[m_addr][m_id] = 1'b1;
            end
            m_rr = (m_id + 1) % NC;
            m_phase = 0;
        end
    endtask

    task automatic drain(input string nm, input int max, output int n);
        n = 0;
        while (pend_v != 0 && n < max) begin
            cycle();
            n++;
        end
        ncmp++;
        if (pend_v != 0) begin
            nfail++;
            $display("FAIL %s: pending=%b after %0d cycles, want 0000", nm, pend_v, n);
        end
    endtask

    task automatic issue(input int i, input bit ex, input int a);
        pend_v[i] = 1'b1; pend_excl[i] = ex; pend_addr[i] = a;
    endtask

    initial begin
        int n;
        reset = 1'b1; rst_next = 1'b1; rand_mode = 0;
        req = '0; req_addr = '0; back_data = '0; pend_v = '0;
        for (int i = 0; i < NC; i++) begin
            pend_excl[i] = 0; pend_addr[i] = 0; wb_delay[i] = 1; wb_cnt[i] = 0; wb_data[i] = 0;
        end
        model_reset();
        cycle(); cycle();
        rst_next = 0;
        cycle();
        chk("reset_outputs", 32'(cap_all), 32'd0);

        // 1: single read, grant one cycle after arbitration
        issue(1, 0, 3);
        drain("t1_drain", 10, n);
        chk("t1_cycles", n, 2);
        chk("t1_blk_ok", last_ok, 4'b0010);
        chk("t1_blk_data", last_data, 0);
        chk("t1_model_sharers", m_sh[3], 4'b0010);

        // 2: three readers, then exclusive request invalidates them
        issue(0, 0, 5); issue(2, 0, 5); issue(3, 0, 5);
        grants.delete();
        drain("t2_reads", 20, n);
        chk("t2_order", {grants[0][7:0], grants[1][7:0], grants[2][7:0]}, 24'h020300);
        issue(1, 1, 5);
        drain("t2_excl", 10, n);
        chk("t2_inval", last_inval, 4'b1101);
        chk("t2_blocknum", last_bn, 5);
        chk("t2_blk_ok", last_ok, 4'b0010);
        chk("t2_model_owner", {m_ov[5], 8'(m_own[5]), m_sh[5]}, {1'b1, 8'd1, 4'b0000});

        // 3: recall from owner with a three-cycle response
        wb_delay[1] = 3; wb_data[1] = 1; wb_cycles = 0;
        issue(2, 0, 5);
        drain("t3_drain", 20, n);
        chk("t3_wb_cycles", wb_cycles, 3);
        chk("t3_blk_ok", last_ok, 4'b0100);
        chk("t3_blk_data", last_data, 1);
        chk("t3_model_sharers", m_sh[5], 4'b0110);

        // 4: all four read together with the pointer at 2
        issue(1, 0, 7);
        drain("t4_prep", 10, n);
        chk("t4_model_rr", m_rr, 2);
        grants.delete();
        for (int i = 0; i < NC; i++) issue(i, 0, 9);
        drain("t4_drain", 30, n);
        chk("t4_order", {grants[0][7:0], grants[1][7:0], grants[2][7:0], grants[3][7:0]},
            32'h02030001);

        // 5: reset while waiting for a write-back; the late wb_ok must not land
        issue(0, 1, 2);
        drain("t5_prep", 10, n);
        wb_delay[0] = 2; wb_data[0] = 1;
        issue(3, 0, 2);
        n = 0;
        while (cap_wb != 4'b0001 && n < 20) begin cycle(); n++; end
        chk("t5_wait_reached", cap_wb, 4'b0001);
        rst_next = 1;
        cycle();
        rst_next = 0;
        cycle();
        chk("t5_outputs_zero", 32'(cap_all), 32'd0);
        drain("t5_drain", 10, n);
        chk("t5_blk_ok", last_ok, 4'b1000);
        chk("t5_blk_data", last_data, 0);

        // Randomized traffic with occasional resets
        rand_mode = 1;
        for (int t = 0; t < 4000; t++) begin
            rst_next = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst_next = 0;
        rand_mode = 0;
        drain("rand_drain", 300, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
